nibble_sum_accumulator: RTL
===========================

Name: nibble_sum_accumulator

Overview:
- Downstream consumer of the registered nibble-adder stage. Takes its 5-bit sums (4-bit sum plus carry) over a valid/ready link.
- Accumulates a fixed window of WINDOW samples into a saturating ACC_W-bit total.
- Presents the total, with a saturation flag, on a valid/ready output port for the next stage (display/serial out).

Parameters:
- SUM_W, 5, width of each incoming sum sample.
- ACC_W, 8, accumulator and result width.
- WINDOW, 16, samples per window; legal range 1..255.

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- clear  input  1  synchronous abort: discard the current window
- in_valid  input  1  upstream sample valid
- in_ready  output  1  block can accept a sample this cycle
- in_data  input  SUM_W  upstream sum sample, unsigned
- out_valid  output  1  window result available
- out_ready  input  1  downstream accepts the result
- out_sum  output  ACC_W  saturated window total
- out_sat  output  1  saturation occurred during this window
- out_count  output  8  samples accepted so far in the current window

Behaviour:
- Reset (async, active-high; clock clk): state=ACCUM, acc=0, count=0, sat=0, out_valid=0, out_sum=0, out_sat=0, out_count=0. in_ready follows state after reset, so it reads 1.
- States: ACCUM and HOLD.
- in_ready = (state==ACCUM) & ~clear. Combinational; it does not depend on in_valid.
- ACCUM, on accept (in_valid & in_ready):
  - sum_next = acc + zero-extended in_data, computed at ACC_W+1 bits.
  - If sum_next > 2^ACC_W-1: acc <= 2^ACC_W-1 and sat <= 1. sat is sticky for the rest of the window.
  - Otherwise acc <= sum_next.
  - count <= count+1.
- ACCUM, no accept: acc, sat and count hold.
- Window completion: the accept that brings count to WINDOW does all of the following on the same clock edge:
  - out_sum <= the new acc value, including saturation from that final sample.
  - out_sat <= the new sat value.
  - out_valid <= 1; state <= HOLD.
  - Latency: result visible the cycle after the final sample is accepted.
- HOLD:
  - in_ready=0; out_sum and out_sat are stable while out_valid=1.
  - On out_valid & out_ready: out_valid <= 0, acc <= 0, sat <= 0, count <= 0, state <= ACCUM.
  - First new sample can be accepted the cycle after the handshake. This gives exactly one input bubble per window.
- out_count = count. It reads WINDOW throughout HOLD and returns to 0 after the handshake.
- out_valid never drops without out_ready, except on clear or reset.
- clear (synchronous) has priority over every other event:
  - acc=0, sat=0, count=0, out_valid=0, state=ACCUM.
  - out_sum and out_sat retain their last values.
  - A sample presented during clear is not accepted, because in_ready=0.
  - clear during HOLD drops the pending result, even if out_ready=1 that cycle.
- WINDOW=1: every accepted sample produces a result directly.
- Mid-operation async reset returns all state to reset values immediately; no partial result is emitted.
- in_data is treated as unsigned. No wrap-around is possible: the accumulator saturates and never exceeds 2^ACC_W-1.

Test Plan:
- Saturation-free window: 16 samples of in_data=3, in_valid held 1, out_ready=1 → out_valid pulses 1 cycle after 16th accept; out_sum=48, out_sat=0, out_count=16; in_ready=0 for exactly one cycle.
- Saturation: 16 samples of 31, expected raw total 496 → out_sum=255, out_sat=1. Next window of 16×1 → out_sum=16, out_sat=0 (sat cleared).
- Backpressure: complete a window of 16×2 with out_ready=0 for 5 cycles → out_valid stays 1, out_sum=32 stable, in_ready=0 and in_valid ignored; raise out_ready → out_valid falls next cycle, out_count=0.
- Gapped input: 16 samples of 5 with in_valid toggling randomly → out_sum=80; out_count increments only on accepted cycles.
- Clear: accept 7 samples of 9, assert clear 1 cycle with in_valid=1 → out_count=0, that sample not counted; then 16×1 → out_sum=16. Clear in HOLD with out_ready=1 → out_valid=0, no handshake counted.
- Async reset mid-window: after 10 samples, pulse reset between clock edges → all outputs 0 immediately; in_ready=1 once reset deasserts.

Source files
------------

// File: rtl/nibble_sum_accumulator.sv
// Windowed, saturating accumulator for the 5-bit sums of the nibble-adder stage.
// It collects WINDOW samples and offers the total and a saturation flag downstream over valid/ready.
module nibble_sum_accumulator #(
    parameter int SUM_W  = 5,
    parameter int ACC_W  = 8,
    parameter int WINDOW = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_sat,
    output logic [7:0]       out_count
);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam logic [7:0]       WINDOW_C = 8'(WINDOW);
    localparam logic [ACC_W-1:0] ACC_MAX  = '1;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             sat_q, sat_d;
    logic [7:0]       count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic             out_sat_q, out_sat_d;

    logic             accept;
    logic [ACC_W:0]   sum_next;
    logic [ACC_W-1:0] acc_new;
    logic             sat_new;
    logic [7:0]       count_inc;
    logic             window_done;

    assign in_ready = (state_q == ST_ACCUM) && !clear;
    assign accept   = in_valid && in_ready;

    // One extra bit catches overflow; the MSB set means the total passed ACC_MAX.
    assign sum_next    = {1'b0, acc_q} + (ACC_W + 1)'(in_data);
    assign acc_new     = sum_next[ACC_W] ? ACC_MAX : sum_next[ACC_W-1:0];
    assign sat_new     = sat_q || sum_next[ACC_W];
    assign count_inc   = count_q + 8'd1;
    assign window_done = (count_inc == WINDOW_C);

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through this block can infer a latch.
        state_d     = state_q;
        acc_d       = acc_q;
        sat_d       = sat_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_sat_d   = out_sat_q;

        if (clear) begin
            // Abort wins over everything; the last published result stays on out_sum/out_sat.
            state_d     = ST_ACCUM;
            acc_d       = '0;
            sat_d       = 1'b0;
            count_d     = '0;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_ACCUM: begin
                    if (accept) begin
                        acc_d   = acc_new;
                        sat_d   = sat_new;
                        count_d = count_inc;
                        if (window_done) begin
                            out_sum_d   = acc_new;
                            out_sat_d   = sat_new;
                            out_valid_d = 1'b1;
                            state_d     = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_valid_q && out_ready) begin
                        state_d     = ST_ACCUM;
                        acc_d       = '0;
                        sat_d       = 1'b0;
                        count_d     = '0;
                        out_valid_d = 1'b0;
                    end
                end
                default: state_d = ST_ACCUM;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_sat   = out_sat_q;
    assign out_count = count_q;

endmodule
